tug_referee: RTL and testbench



---
 rtl/tug_referee_if.sv | 16 +
 rtl/tug_referee.sv | 127 ++++++++++++
 tb/tb_tug_referee.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tug_referee_if.sv
// tug_if: signal bundle between the game controller/buttons and the round referee.
interface tug_if;
    logic       btn_l, btn_r, slowen256;
    logic       leds_on, clear, fake, speed_round, update;
    logic       winrnd, winspeed, speed_exit, wingame, over, winner;
    logic [3:0] rope_pos;
    logic [1:0] score_l, score_r;
    modport slave (
        input  btn_l, btn_r, slowen256, leds_on, clear, fake, speed_round, update,
        output winrnd, winspeed, speed_exit, wingame, over, winner, rope_pos, score_l, score_r
    );
    modport master (
        output btn_l, btn_r, slowen256, leds_on, clear, fake, speed_round, update,
        input  winrnd, winspeed, speed_exit, wingame, over, winner, rope_pos, score_l, score_r
    );
endinterface

// File: rtl/tug_referee.sv
// tug_referee: conditions player buttons, judges normal and speed rounds,
// moves the rope and keeps game scores for the tug-of-war controller.
module tug_referee #(
    parameter int HALF          = 4,
    parameter int GAMES_TO_WIN  = 3,
    parameter int SPEED_PRESSES = 8,
    parameter int SPEED_STEP    = 2,
    parameter int DISPLAY_TICKS = 2
) (
    input logic clk,
    input logic rst,
    tug_if.slave bus
);
    localparam logic [1:0] SP_IDLE  = 2'd0;
    localparam logic [1:0] SP_COUNT = 2'd1;
    localparam logic [1:0] SP_DISP  = 2'd2;
    localparam logic [3:0] MID   = 4'(HALF);
    localparam logic [3:0] TOP   = 4'(2 * HALF);
    localparam logic [3:0] STEP  = 4'(SPEED_STEP);
    localparam logic [3:0] NEED  = 4'(SPEED_PRESSES);
    localparam logic [1:0] GAMES = 2'(GAMES_TO_WIN);
    localparam logic [1:0] TICKS = 2'(DISPLAY_TICKS);

    logic [2:0] sync_l_q, sync_l_d, sync_r_q, sync_r_d;
    logic       press_l_q, press_l_d, press_r_q, press_r_d;
    logic       sr_q, upd_q, lock_q, lock_d;
    logic [1:0] sp_q, sp_d, tick_q, tick_d, tick_inc;
    logic [3:0] cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d, cnt_l_inc, cnt_r_inc;
    logic [3:0] rope_q, rope_d, rope_nx, step_up, step_dn;
    logic [1:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic       winner_q, winner_d, wingame_q, wingame_d, over_q, over_d;
    logic       winrnd_q, winspeed_q, exit_q;
    logic       judge, rnd_win, counting, l_done, r_done, sp_win, move, upd, disp_done;

    always_comb begin
        // [0] first sync flop, [1] second, [2] previous value for edge detect
        sync_l_d  = {sync_l_q[1:0], bus.btn_l};
        sync_r_d  = {sync_r_q[1:0], bus.btn_r};
        press_l_d = sync_l_q[1] & ~sync_l_q[2];
        press_r_d = sync_r_q[1] & ~sync_r_q[2];
        judge     = ~bus.clear & ~lock_q & ~wingame_q & ~over_q & ~bus.speed_round
                  & (sp_q == SP_IDLE) & (press_l_q ^ press_r_q);
        rnd_win   = (bus.leds_on & ~bus.fake) ? press_r_q : press_l_q;
        counting  = (sp_q == SP_COUNT) & ~over_q;
        cnt_l_inc = cnt_l_q + {3'b0, press_l_q};
        cnt_r_inc = cnt_r_q + {3'b0, press_r_q};
        l_done    = cnt_l_inc == NEED;
        r_done    = cnt_r_inc == NEED;
        sp_win    = counting & (l_done | r_done);
        step_up   = (rope_q > TOP - STEP) ? TOP : rope_q + STEP;
        step_dn   = (rope_q < STEP) ? 4'd0 : rope_q - STEP;
        rope_nx   = judge ? (rnd_win ? rope_q + 4'd1 : rope_q - 4'd1) : (l_done ? step_dn : step_up);
        move      = (judge | sp_win) & ~wingame_q;
        upd       = bus.update & ~upd_q & wingame_q & ~over_q;
        rope_d    = upd ? MID : move ? rope_nx : rope_q;
        wingame_d = upd ? 1'b0 : move ? (rope_nx == 4'd0 || rope_nx == TOP) : wingame_q;
        winner_d  = judge ? rnd_win : sp_win ? ~l_done : winner_q;
        score_l_d = score_l_q + {1'b0, upd & ~winner_q};
        score_r_d = score_r_q + {1'b0, upd & winner_q};
        over_d    = over_q | (score_l_q == GAMES) | (score_r_q == GAMES);
        lock_d    = (judge | sp_win) ? 1'b1
                  : (bus.clear & ~bus.speed_round & (sp_q != SP_DISP)) ? 1'b0 : lock_q;
        tick_inc  = tick_q + {1'b0, bus.slowen256};
        disp_done = (sp_q == SP_DISP) & bus.slowen256 & (tick_inc == TICKS);
        sp_d      = ((sp_q == SP_IDLE) & bus.speed_round & ~sr_q & ~over_q) ? SP_COUNT
                  : sp_win ? SP_DISP : disp_done ? SP_IDLE : sp_q;
        cnt_l_d   = (sp_q == SP_IDLE) ? 4'd0 : counting ? cnt_l_inc : cnt_l_q;
        cnt_r_d   = (sp_q == SP_IDLE) ? 4'd0 : counting ? cnt_r_inc : cnt_r_q;
        tick_d    = ((sp_q == SP_DISP) & ~disp_done) ? tick_inc : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_l_q   <= '0;
            sync_r_q   <= '0;
            press_l_q  <= 1'b0;
            press_r_q  <= 1'b0;
            sr_q       <= 1'b0;
            upd_q      <= 1'b0;
            lock_q     <= 1'b0;
            sp_q       <= SP_IDLE;
            tick_q     <= '0;
            cnt_l_q    <= '0;
            cnt_r_q    <= '0;
            rope_q     <= MID;
            score_l_q  <= '0;
            score_r_q  <= '0;
            winner_q   <= 1'b0;
            wingame_q  <= 1'b0;
            over_q     <= 1'b0;
            winrnd_q   <= 1'b0;
            winspeed_q <= 1'b0;
            exit_q     <= 1'b0;
        end else begin
            sync_l_q   <= sync_l_d;
            sync_r_q   <= sync_r_d;
            press_l_q  <= press_l_d;
            press_r_q  <= press_r_d;
            sr_q       <= bus.speed_round;
            upd_q      <= bus.update;
            lock_q     <= lock_d;
            sp_q       <= sp_d;
            tick_q     <= tick_d;
            cnt_l_q    <= cnt_l_d;
            cnt_r_q    <= cnt_r_d;
            rope_q     <= rope_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            winner_q   <= winner_d;
            wingame_q  <= wingame_d;
            over_q     <= over_d;
            winrnd_q   <= judge;
            winspeed_q <= sp_win;
            exit_q     <= disp_done;
        end
    end

    assign bus.winrnd     = winrnd_q;
    assign bus.winspeed   = winspeed_q;
    assign bus.speed_exit = exit_q;
    assign bus.wingame    = wingame_q;
    assign bus.over       = over_q;
    assign bus.winner     = winner_q;
    assign bus.rope_pos   = rope_q;
    assign bus.score_l    = score_l_q;
    assign bus.score_r    = score_r_q;
endmodule

// File: tb/tb_tug_referee.sv
// tb_tug_referee: directed scenarios for the referee with a queue of expected
// round/speed outcomes popped as the decision pulses appear.
module tb_tug_referee;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tug_if bus();
    tug_referee u_dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed { logic w; logic [3:0] rope; } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    localparam logic [13:0] RST_V = {5'b0, 1'b0, 4'd4, 2'd0, 2'd0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] outs();
        return {bus.winrnd, bus.winspeed, bus.speed_exit, bus.wingame, bus.over, bus.winner,
                bus.rope_pos, bus.score_l, bus.score_r};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {bus.btn_l, bus.btn_r, bus.slowen256, bus.leds_on} = '0;
        {bus.clear, bus.fake, bus.speed_round, bus.update} = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic clr();
        @(negedge clk) bus.clear = 1'b1;
        @(negedge clk) bus.clear = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk) bus.slowen256 = 1'b1;
        @(negedge clk) bus.slowen256 = 1'b0;
    endtask

    // Hold the button(s) for 8 cycles: also shows a held button does not repeat.
    task automatic hit(input string tag, input logic l, input logic r, input logic exp_win,
                       input logic w, input logic [3:0] rp);
        int lat = 0;
        int np = 0;
        if (exp_win) sb.push_back({w, rp});
        @(negedge clk);
        bus.btn_l = l;
        bus.btn_r = r;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.winrnd) begin
                np++;
                if (lat == 0) lat = i;
                if (sb.size() > 0) begin
                    exp_t e = sb.pop_front();
                    chk({tag, "_winner"}, {31'b0, bus.winner}, {31'b0, e.w});
                    chk({tag, "_rope"}, {28'b0, bus.rope_pos}, {28'b0, e.rope});
                end
            end
        end
        bus.btn_l = 1'b0;
        bus.btn_r = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_pulses"}, np, {31'b0, exp_win});
        if (exp_win) chk({tag, "_latency"}, lat, 4);
        chk({tag, "_pending"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic spress(input logic l, input logic r);
        @(negedge clk);
        bus.btn_l = l;
        bus.btn_r = r;
        @(negedge clk);
        bus.btn_l = 1'b0;
        bus.btn_r = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_speed(input string tag);
        int lat = 0;
        int np = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.winspeed) begin
                np++;
                if (lat == 0) lat = i;
                if (sb.size() > 0) begin
                    exp_t e = sb.pop_front();
                    chk({tag, "_winner"}, {31'b0, bus.winner}, {31'b0, e.w});
                    chk({tag, "_rope"}, {28'b0, bus.rope_pos}, {28'b0, e.rope});
                end
            end
        end
        chk({tag, "_pulses"}, np, 1);
        chk({tag, "_latency"}, lat, 1);
        chk({tag, "_pending"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        {bus.btn_l, bus.btn_r, bus.slowen256, bus.leds_on} = '0;
        {bus.clear, bus.fake, bus.speed_round, bus.update} = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset", outs(), RST_V);

        bus.leds_on = 1'b1;
        hit("play_r", 1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
        hit("play_locked", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("locked_rope", bus.rope_pos, 5);

        do_reset();
        hit("dark_l", 1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
        do_reset();
        bus.leds_on = 1'b1;
        bus.fake = 1'b1;
        hit("fake_l", 1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
        do_reset();
        bus.leds_on = 1'b1;
        hit("both", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("both_rope", bus.rope_pos, 4);

        do_reset();
        @(negedge clk) bus.update = 1'b1;
        @(negedge clk) bus.update = 1'b0;
        chk("idle_update", {bus.score_l, bus.score_r, bus.rope_pos}, {2'd0, 2'd0, 4'd4});
        bus.leds_on = 1'b1;
        for (int g = 1; g <= 3; g++) begin
            for (int k = 1; k <= 4; k++) begin
                hit("game_r", 1'b0, 1'b1, 1'b1, 1'b1, 4'(4 + k));
                clr();
            end
            chk("wingame", {bus.wingame, bus.rope_pos}, {1'b1, 4'd8});
            @(negedge clk) bus.update = 1'b1;
            @(negedge clk);
            chk("update", {bus.score_l, bus.score_r, bus.rope_pos, bus.wingame, bus.over},
                {2'd0, 2'(g), 4'd4, 1'b0, 1'b0});
            bus.update = 1'b0;
            @(negedge clk);
            chk("over", bus.over, g == 3);
        end
        hit("after_over", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("after_over_state", {bus.rope_pos, bus.score_r, bus.over}, {4'd4, 2'd3, 1'b1});

        do_reset();
        bus.clear = 1'b1;
        bus.speed_round = 1'b1;
        @(negedge clk);
        sb.push_back({1'b0, 4'd2});
        for (int i = 0; i < 8; i++) spress(1'b1, i < 5);
        wait_speed("speed");
        tick();
        chk("exit_early", bus.speed_exit, 0);
        tick();
        chk("exit", bus.speed_exit, 1);
        @(negedge clk);
        chk("exit_pulse", bus.speed_exit, 0);

        do_reset();
        bus.clear = 1'b1;
        bus.speed_round = 1'b1;
        @(negedge clk);
        sb.push_back({1'b0, 4'd2});
        for (int i = 0; i < 8; i++) spress(1'b1, 1'b1);
        wait_speed("tie");

        tick();
        chk("disp_tick1", bus.speed_exit, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.speed_round = 1'b0;
        bus.clear = 1'b0;
        bus.slowen256 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.slowen256 = 1'b0;
        chk("rst_disp", outs(), RST_V);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("no_exit", bus.speed_exit, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
